// File: rtl/sto_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sto_pkg
// Description : Shared definitions for the sto datapath (act feeder, weight
//               loader, top-level sequencer): FSM state encoding and the
//               lane / pointer width helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package sto_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } sto_state_e;

  // Number of PE lanes obtained by slicing one full multi-bank row.
  function automatic int sto_lanes(input int num_banks, input int bank_dw, input int lane_w);
    return (num_banks * bank_dw) / lane_w;
  endfunction

  // $clog2 that never returns 0, so derived vectors always have a bit.
  function automatic int sto_clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sto_skew_line.sv
`default_nettype none
// ============================================================================
// Module      : sto_skew_line
// Description : Per-lane diagonal delay line. Lane l passes through l
//               registers when skew is enabled (lane 0 is combinational),
//               with a valid bit travelling alongside the data. With skew
//               disabled every lane bypasses its chain.
// Ports       : clk, rst           - clock / synchronous active-high reset
//               skew_en_i          - 1 = diagonal skew, 0 = aligned bypass
//               in_valid_i/in_data_i   - registered row from the feeder
//               out_valid_o/out_data_o - per-lane valid and data to the PEs
// Revision    : 1.0 - initial release
// ============================================================================
module sto_skew_line #(
  parameter int LANES  = 32,
  parameter int LANE_W = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      skew_en_i,
  input  logic                      in_valid_i,
  input  logic [LANES*LANE_W-1:0]   in_data_i,
  output logic [LANES-1:0]          out_valid_o,
  output logic [LANES*LANE_W-1:0]   out_data_o
);

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    if (l == 0) begin : g_direct
      assign out_data_o[LANE_W-1:0] = in_data_i[LANE_W-1:0];
      assign out_valid_o[0]         = in_valid_i;
    end else begin : g_delay
      logic [LANE_W-1:0] dat_q [l];
      logic              vld_q [l];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < l; i++) begin
            dat_q[i] <= '0;
            vld_q[i] <= 1'b0;
          end
        end else begin
          // Chains only load while skewing so the bypass path leaves them empty.
          vld_q[0] <= in_valid_i && skew_en_i;
          dat_q[0] <= skew_en_i ? in_data_i[l*LANE_W +: LANE_W] : '0;
          for (int i = 1; i < l; i++) begin
            vld_q[i] <= vld_q[i-1];
            dat_q[i] <= dat_q[i-1];
          end
        end
      end

      assign out_data_o[l*LANE_W +: LANE_W] = skew_en_i ? dat_q[l-1] : in_data_i[l*LANE_W +: LANE_W];
      assign out_valid_o[l]                 = skew_en_i ? vld_q[l-1] : in_valid_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sto_act_feeder.sv
`default_nettype none
// ============================================================================
// Module      : sto_act_feeder
// Description : Activation streamer for the systolic array. On start it reads
//               tran_time rows from NUM_BANKS act SRAM banks in lockstep,
//               realigns the per-bank returns through small FIFOs, registers
//               each aligned row and slices it into LANES elements with an
//               optional diagonal skew.
// Ports       : clk, rst                 - clock / sync active-high reset
//               start, tran_time,
//               base_addr, skew_en       - launch pulse and job parameters
//               busy, done, err          - status (err = sticky FIFO overflow)
//               bce, braddr              - per-bank read enable / address
//               brdata, brvalid          - per-bank read return
//               act_pe_valid, act_pe_o   - lane stream to the PE array
// Revision    : 1.0 - initial release
// ============================================================================
module sto_act_feeder #(
  parameter int NUM_BANKS   = 4,
  parameter int BANK_DW     = 64,
  parameter int ADDR_W      = 15,
  parameter int LANE_W      = 8,
  parameter int TIME_W      = 12,
  parameter int ALIGN_DEPTH = 4
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         start,
  input  logic [TIME_W-1:0]                            tran_time,
  input  logic [ADDR_W-1:0]                            base_addr,
  input  logic                                         skew_en,
  output logic                                         busy,
  output logic                                         done,
  output logic                                         err,
  output logic [NUM_BANKS-1:0]                         bce,
  output logic [NUM_BANKS*ADDR_W-1:0]                  braddr,
  input  logic [NUM_BANKS*BANK_DW-1:0]                 brdata,
  input  logic [NUM_BANKS-1:0]                         brvalid,
  output logic                                         act_pe_valid,
  output logic [sto_pkg::sto_lanes(NUM_BANKS, BANK_DW, LANE_W)*LANE_W-1:0] act_pe_o
);
  import sto_pkg::*;

  localparam int LANES = sto_lanes(NUM_BANKS, BANK_DW, LANE_W);
  localparam int ROW_W = NUM_BANKS * BANK_DW;
  localparam int PTR_W = sto_clog2_min1(ALIGN_DEPTH);
  localparam int CNT_W = $clog2(ALIGN_DEPTH + 1);
  localparam int DRN_W = sto_clog2_min1(LANES);

  sto_state_e          state_q;
  logic                busy_q, done_q, err_q, skew_en_q;
  logic [NUM_BANKS-1:0] bce_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [TIME_W-1:0]   tran_time_q, issue_cnt_q, pop_cnt_q;
  logic [DRN_W-1:0]    drain_cnt_q;

  logic                launch;
  logic                pop;
  logic [NUM_BANKS-1:0] nonempty, ovf, rcv_done;
  logic [ROW_W-1:0]    head;

  logic [ROW_W-1:0]    row_q;
  logic                row_vld_q;
  logic [LANES-1:0]    lane_vld;

  assign launch = start && (state_q == ST_IDLE);
  // A row leaves the FIFOs only once every bank has its slice; the count guard
  // keeps stale entries from an overflowed job from ever being emitted.
  assign pop    = (&nonempty) && (state_q == ST_ISSUE || state_q == ST_WAIT) &&
                  (pop_cnt_q != tran_time_q);

  // --------------------------------------------------------------------------
  // Per-bank alignment FIFOs
  // --------------------------------------------------------------------------
  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [BANK_DW-1:0] mem_q [ALIGN_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [TIME_W-1:0]  rcv_cnt_q;
    logic               push, full, push_ok;

    assign push        = brvalid[b] && busy_q;
    assign full        = (cnt_q == CNT_W'(ALIGN_DEPTH));
    // A simultaneous pop frees the slot the push needs.
    assign push_ok     = push && (!full || pop);
    assign ovf[b]      = push && full && !pop;
    assign nonempty[b] = (cnt_q != '0);
    assign rcv_done[b] = (rcv_cnt_q == tran_time_q);
    assign head[b*BANK_DW +: BANK_DW] = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
      if (rst || launch) begin
        wr_ptr_q  <= '0;
        rd_ptr_q  <= '0;
        cnt_q     <= '0;
        rcv_cnt_q <= '0;
        for (int i = 0; i < ALIGN_DEPTH; i++) mem_q[i] <= '0;
      end else begin
        // Dropped returns still count so an overflowed job can terminate.
        if (push) rcv_cnt_q <= rcv_cnt_q + TIME_W'(1);
        if (push_ok) begin
          mem_q[wr_ptr_q] <= brdata[b*BANK_DW +: BANK_DW];
          wr_ptr_q <= (wr_ptr_q == PTR_W'(ALIGN_DEPTH-1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr_q <= (rd_ptr_q == PTR_W'(ALIGN_DEPTH-1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        if (push_ok && !pop)      cnt_q <= cnt_q + CNT_W'(1);
        else if (!push_ok && pop) cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Sequencer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      skew_en_q   <= 1'b0;
      bce_q       <= '0;
      addr_q      <= '0;
      tran_time_q <= '0;
      issue_cnt_q <= '0;
      pop_cnt_q   <= '0;
      drain_cnt_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (|ovf) err_q <= 1'b1;
      if (pop)  pop_cnt_q <= pop_cnt_q + TIME_W'(1);

      case (state_q)
        ST_IDLE: begin
          if (start) begin
            tran_time_q <= tran_time;
            skew_en_q   <= skew_en;
            addr_q      <= base_addr;
            bce_q       <= {NUM_BANKS{tran_time != '0}};
            issue_cnt_q <= '0;
            pop_cnt_q   <= '0;
            drain_cnt_q <= '0;
            err_q       <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (tran_time_q == '0) begin
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else if (issue_cnt_q == tran_time_q - TIME_W'(1)) begin
            bce_q   <= '0;
            state_q <= ST_WAIT;
          end else begin
            issue_cnt_q <= issue_cnt_q + TIME_W'(1);
            addr_q      <= addr_q + ADDR_W'(1);
          end
        end
        ST_WAIT: begin
          // Normal exit on the final pop; after an overflow some rows can never
          // assemble, so exit once every bank has returned all its reads.
          if ((pop && pop_cnt_q == tran_time_q - TIME_W'(1)) ||
              (err_q && (&rcv_done) && !pop)) begin
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // Entered as the last row sits in the output register; the skew
          // chains need LANES-1 further cycles to empty.
          if (drain_cnt_q == (skew_en_q ? DRN_W'(LANES-1) : DRN_W'(0))) begin
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            drain_cnt_q <= drain_cnt_q + DRN_W'(1);
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Output row register and skew
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      row_q     <= '0;
      row_vld_q <= 1'b0;
    end else begin
      row_vld_q <= pop;
      row_q     <= pop ? head : '0;
    end
  end

  sto_skew_line #(
    .LANES  (LANES),
    .LANE_W (LANE_W)
  ) u_skew (
    .clk         (clk),
    .rst         (rst),
    .skew_en_i   (skew_en_q),
    .in_valid_i  (row_vld_q),
    .in_data_i   (row_q),
    .out_valid_o (lane_vld),
    .out_data_o  (act_pe_o)
  );

  assign act_pe_valid = |lane_vld;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign bce          = bce_q;
  assign braddr       = {NUM_BANKS{addr_q}};

endmodule
`default_nettype wire

// File: tb/tb_sto_act_feeder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_sto_act_feeder
// Description : Self-checking bench for sto_act_feeder with a latency-per-bank
//               SRAM model and a row/lane reference grid.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sto_act_feeder;
  localparam int NUM_BANKS = 4, BANK_DW = 64, ADDR_W = 15, LANE_W = 8, TIME_W = 12, ALIGN_DEPTH = 4;
  localparam int LANES = NUM_BANKS * BANK_DW / LANE_W;
  localparam int EPB   = BANK_DW / LANE_W;
  localparam int MAXC  = 256;

  logic clk, rst, start, skew_en, busy, done, err, act_pe_valid;
  logic [TIME_W-1:0]            tran_time;
  logic [ADDR_W-1:0]            base_addr;
  logic [NUM_BANKS-1:0]         bce, brvalid;
  logic [NUM_BANKS*ADDR_W-1:0]  braddr;
  logic [NUM_BANKS*BANK_DW-1:0] brdata;
  logic [LANES*LANE_W-1:0]      act_pe_o;

  sto_act_feeder #(
    .NUM_BANKS(NUM_BANKS), .BANK_DW(BANK_DW), .ADDR_W(ADDR_W),
    .LANE_W(LANE_W), .TIME_W(TIME_W), .ALIGN_DEPTH(ALIGN_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .tran_time(tran_time), .base_addr(base_addr),
    .skew_en(skew_en), .busy(busy), .done(done), .err(err), .bce(bce), .braddr(braddr),
    .brdata(brdata), .brvalid(brvalid), .act_pe_valid(act_pe_valid), .act_pe_o(act_pe_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // ---------------- SRAM model: fixed latency per bank ----------------------
  typedef struct { int bank; int due; logic [ADDR_W-1:0] addr; } req_t;
  req_t rq[$];
  req_t keep[$];
  int   lat [NUM_BANKS];
  int   cyc;
  logic [31:0] salt;

  function automatic logic [BANK_DW-1:0] mem_word(input int b, input logic [ADDR_W-1:0] a);
    logic [31:0] hi;
    hi = salt ^ {2'b0, a, 15'(b)};
    return {hi, 8'(b), 8'h5A, 1'b0, a};
  endfunction

  function automatic logic [LANE_W-1:0] exp_lane(input int l, input logic [ADDR_W-1:0] a);
    logic [BANK_DW-1:0] w;
    w = mem_word(l / EPB, a);
    return w[(l % EPB)*LANE_W +: LANE_W];
  endfunction

  initial begin
    cyc = 0; brvalid = '0; brdata = '0;
    forever begin
      @(negedge clk);
      cyc++;
      for (int b = 0; b < NUM_BANKS; b++)
        if (bce[b] === 1'b1) rq.push_back('{b, cyc + lat[b], braddr[b*ADDR_W +: ADDR_W]});
      keep.delete();
      brvalid = '0;
      brdata  = '0;
      foreach (rq[i]) begin
        if (rq[i].due == cyc) begin
          brvalid[rq[i].bank] = 1'b1;
          brdata[rq[i].bank*BANK_DW +: BANK_DW] = mem_word(rq[i].bank, rq[i].addr);
        end else keep.push_back(rq[i]);
      end
      rq = keep;
    end
  end

  // ---------------- capture of one job --------------------------------------
  logic [LANES*LANE_W-1:0]     act_log [MAXC];
  logic                        v_log [MAXC], d_log [MAXC], b_log [MAXC], e_log [MAXC];
  logic [NUM_BANKS-1:0]        bce_log [MAXC];
  logic [NUM_BANKS*ADDR_W-1:0] addr_log [MAXC];
  int ncyc;

  // Cycle 0 = first cycle after the start edge.
  task automatic run_op(input int t, input int base, input bit sk, input int inject_at);
    int c, post;
    bit seen;
    salt = $urandom;
    @(negedge clk);
    tran_time = TIME_W'(t); base_addr = ADDR_W'(base); skew_en = sk; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c = 0; post = 0; seen = 0;
    while (c < MAXC && post < 3) begin
      act_log[c] = act_pe_o; v_log[c] = act_pe_valid; d_log[c] = done;
      b_log[c] = busy; e_log[c] = err; bce_log[c] = bce; addr_log[c] = braddr;
      if (done === 1'b1) seen = 1;
      if (seen) post++;
      if (c == inject_at) begin
        start = 1'b1; tran_time = TIME_W'(3); base_addr = 15'h0100; skew_en = ~sk;
      end else start = 1'b0;
      c++;
      @(negedge clk);
    end
    start = 1'b0;
    ncyc = c;
  endtask

  // Observed statistics plus mismatch count against the reference grid:
  // row k lane l is expected at first_valid + k (+ l when skewed), zero elsewhere.
  int bce_cnt, bce_bad, addr_bad, v_cnt, v_first, v_last, done_cnt, done_cyc, grid_bad;
  int g_c, g_l;
  logic [LANE_W-1:0] g_act, g_exp;

  task automatic analyze(input int t, input int base, input bit sk);
    logic [LANE_W-1:0] e;
    int r;
    bce_cnt = 0; bce_bad = 0; addr_bad = 0; v_cnt = 0; v_first = -1; v_last = -1;
    done_cnt = 0; done_cyc = -1; grid_bad = 0;
    for (int c = 0; c < ncyc; c++) begin
      if (bce_log[c] === {NUM_BANKS{1'b1}}) begin
        if (addr_log[c] !== {NUM_BANKS{ADDR_W'(base + bce_cnt)}}) addr_bad++;
        if (c != bce_cnt) bce_bad++;
        bce_cnt++;
      end else if (bce_log[c] !== '0) bce_bad++;
      if (v_log[c] === 1'b1) begin
        if (v_first < 0) v_first = c;
        v_last = c; v_cnt++;
      end
      if (d_log[c] === 1'b1) begin done_cnt++; done_cyc = c; end
    end
    for (int c = 0; c < ncyc; c++) begin
      for (int l = 0; l < LANES; l++) begin
        e = '0;
        if (v_first >= 0) begin
          r = c - v_first - (sk ? l : 0);
          if (r >= 0 && r < t) e = exp_lane(l, ADDR_W'(base + r));
        end
        if (act_log[c][l*LANE_W +: LANE_W] !== e) begin
          if (grid_bad == 0) begin g_c = c; g_l = l; g_act = act_log[c][l*LANE_W +: LANE_W]; g_exp = e; end
          grid_bad++;
        end
      end
    end
  endtask

  // ---------------- tests ----------------------------------------------------
  task automatic test_reset;
    rst = 1'b1; start = 1'b0; tran_time = '0; base_addr = '0; skew_en = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({busy, done, err, act_pe_valid, bce} !== '0 || braddr !== '0 || act_pe_o !== '0) begin
      tests_failed++;
      $display("FAIL reset_state: got busy=%b done=%b err=%b vld=%b bce=%b, required all 0", busy, done, err, act_pe_valid, bce);
    end
    start = 1'b1; tran_time = TIME_W'(8);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || bce !== '0) begin
      tests_failed++;
      $display("FAIL reset_beats_start: got busy=%b bce=%b, required 0/0", busy, bce);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_stream_default;
    foreach (lat[b]) lat[b] = 1;
    run_op(32, 0, 1'b1, -1);
    analyze(32, 0, 1'b1);
    tests_run++;
    if (bce_cnt != 32 || bce_bad != 0) begin tests_failed++; $display("FAIL default_bce: got %0d cycles (%0d bad), required 32", bce_cnt, bce_bad); end
    tests_run++;
    if (addr_bad != 0) begin tests_failed++; $display("FAIL default_addr: got %0d bad addresses, required 0", addr_bad); end
    tests_run++;
    if (v_cnt != 63 || v_last - v_first + 1 != v_cnt) begin tests_failed++; $display("FAIL default_valid: got %0d cycles span %0d..%0d, required 63 contiguous", v_cnt, v_first, v_last); end
    tests_run++;
    if (grid_bad != 0) begin tests_failed++; $display("FAIL default_lanes: cycle %0d lane %0d got %h required %h (%0d bad)", g_c, g_l, g_act, g_exp, grid_bad); end
    tests_run++;
    if (done_cnt != 1 || done_cyc != v_last + 1) begin tests_failed++; $display("FAIL default_done: got %0d pulses at %0d, required 1 at %0d", done_cnt, done_cyc, v_last + 1); end
    tests_run++;
    if (done_cyc < 0 || b_log[done_cyc] !== 1'b1 || b_log[done_cyc+1] !== 1'b0 || e_log[done_cyc] !== 1'b0) begin
      tests_failed++; $display("FAIL default_busy_err: got busy/err at done wrong (done_cyc=%0d), required busy 1 then 0, err 0", done_cyc);
    end
  endtask

  task automatic test_latency_align;
    int t, base;
    for (int it = 0; it < 3; it++) begin
      for (int b = 0; b < NUM_BANKS; b++) lat[b] = (it == 0) ? b + 1 : int'($urandom_range(1, 4));
      t = $urandom_range(8, 40); base = $urandom_range(0, 32767);
      run_op(t, base, 1'b1, -1);
      analyze(t, base, 1'b1);
      tests_run++;
      if (grid_bad != 0 || v_cnt != t + LANES - 1) begin
        tests_failed++; $display("FAIL latency_lanes[%0d]: got %0d bad lanes, %0d valid cycles, required 0 and %0d", it, grid_bad, v_cnt, t + LANES - 1);
      end
      tests_run++;
      if (done_cnt != 1 || done_cyc < 0 || e_log[done_cyc] !== 1'b0) begin
        tests_failed++; $display("FAIL latency_done_err[%0d]: got %0d done pulses, required 1 with err 0", it, done_cnt);
      end
    end
  endtask

  task automatic test_overflow;
    lat[0] = 1; lat[1] = 1; lat[2] = 1; lat[3] = 7;
    run_op(20, $urandom_range(0, 32767), 1'b1, -1);
    analyze(20, 0, 1'b1);
    tests_run++;
    if (done_cnt != 1 || done_cyc < 0 || e_log[done_cyc] !== 1'b1) begin
      tests_failed++; $display("FAIL overflow: got %0d done pulses err=%b, required 1 pulse with err 1", done_cnt, (done_cyc >= 0) ? e_log[done_cyc] : 1'bx);
    end
  endtask

  task automatic test_no_skew;
    int base;
    foreach (lat[b]) lat[b] = 1;
    base = $urandom_range(0, 32767);
    run_op(5, base, 1'b0, -1);
    analyze(5, base, 1'b0);
    tests_run++;
    if (v_cnt != 5 || v_last - v_first + 1 != 5) begin tests_failed++; $display("FAIL noskew_valid: got %0d cycles, required 5 contiguous", v_cnt); end
    tests_run++;
    if (grid_bad != 0) begin tests_failed++; $display("FAIL noskew_lanes: cycle %0d lane %0d got %h required %h", g_c, g_l, g_act, g_exp); end
    tests_run++;
    if (done_cnt != 1 || done_cyc != v_last + 1) begin tests_failed++; $display("FAIL noskew_done: got pulse at %0d, required %0d", done_cyc, v_last + 1); end
  endtask

  task automatic test_addr_wrap;
    foreach (lat[b]) lat[b] = $urandom_range(1, 3);
    run_op(4, 32'h7FFE, 1'b1, -1);
    analyze(4, 32'h7FFE, 1'b1);
    tests_run++;
    if (bce_cnt != 4 || addr_bad != 0 || bce_bad != 0) begin tests_failed++; $display("FAIL wrap_addr: got %0d reads %0d bad addr, required 4 and 0", bce_cnt, addr_bad); end
    tests_run++;
    if (grid_bad != 0) begin tests_failed++; $display("FAIL wrap_lanes: cycle %0d lane %0d got %h required %h", g_c, g_l, g_act, g_exp); end
  endtask

  task automatic test_zero_len_and_ignore;
    int base;
    foreach (lat[b]) lat[b] = 1;
    run_op(0, 5, 1'b1, -1);
    analyze(0, 5, 1'b1);
    tests_run++;
    if (bce_cnt != 0 || bce_bad != 0 || v_cnt != 0) begin tests_failed++; $display("FAIL zero_len_activity: got %0d reads %0d valid, required 0/0", bce_cnt, v_cnt); end
    tests_run++;
    if (done_cnt != 1 || done_cyc != 1) begin tests_failed++; $display("FAIL zero_len_done: got %0d pulses at %0d, required 1 at 1", done_cnt, done_cyc); end
    base = $urandom_range(0, 32767);
    run_op(16, base, 1'b1, 5);
    analyze(16, base, 1'b1);
    tests_run++;
    if (bce_cnt != 16 || addr_bad != 0 || v_cnt != 16 + LANES - 1 || grid_bad != 0 || done_cnt != 1) begin
      tests_failed++; $display("FAIL start_ignored: got %0d reads %0d valid %0d bad lanes %0d done, required 16/%0d/0/1", bce_cnt, v_cnt, grid_bad, done_cnt, 16 + LANES - 1);
    end
  endtask

  task automatic test_mid_reset;
    logic [ADDR_W-1:0] b0;
    int base;
    foreach (lat[b]) lat[b] = 1;
    b0 = ADDR_W'($urandom);
    @(negedge clk);
    tran_time = TIME_W'(40); base_addr = b0; skew_en = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    tests_run++;
    if (braddr !== {NUM_BANKS{b0 + ADDR_W'(10)}}) begin tests_failed++; $display("FAIL midrst_row10: got %h, required %h", braddr[ADDR_W-1:0], b0 + ADDR_W'(10)); end
    rst = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({busy, done, err, act_pe_valid, bce} !== '0 || braddr !== '0 || act_pe_o !== '0) begin
      tests_failed++; $display("FAIL midrst_outputs: got busy=%b vld=%b bce=%b, required all 0", busy, act_pe_valid, bce);
    end
    rst = 1'b0;
    repeat (6) @(negedge clk);
    base = $urandom_range(0, 32767);
    run_op(3, base, 1'b1, -1);
    analyze(3, base, 1'b1);
    tests_run++;
    if (bce_cnt != 3 || v_cnt != 3 + LANES - 1 || grid_bad != 0 || done_cnt != 1) begin
      tests_failed++; $display("FAIL midrst_rerun: got %0d reads %0d valid %0d bad lanes %0d done, required 3/%0d/0/1", bce_cnt, v_cnt, grid_bad, done_cnt, 3 + LANES - 1);
    end
  endtask

  initial begin
    foreach (lat[b]) lat[b] = 1;
    salt = '0;
    test_reset();
    test_stream_default();
    test_latency_align();
    test_overflow();
    test_no_skew();
    test_addr_wrap();
    test_zero_len_and_ignore();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
